// File: rtl/sonar_pkg.sv
// sonar_pkg: sequencer states, byte-engine opcodes and SRF08 register constants.
package sonar_pkg;
   typedef enum logic [3:0] {
      IDLE, SELECT, W_ADDR, W_REG, W_CMD, WAIT, R_ADDRW, R_REG, R_ADDRR, R_HI, R_LO, ABORT, DONE
   } state_t;
   typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_STOP = 2'b10} op_t;
   localparam logic [7:0] REG_CMD = 8'h00, CMD_RANGE_CM = 8'h51, REG_RANGE_HI = 8'h02;
   // The per-channel transaction states are declared in bus order, so a step is an increment.
   function automatic state_t next_step(state_t s);
      return state_t'(s + 4'd1);
   endfunction
endpackage

// File: rtl/sonar_rr_picker.sv
// sonar_rr_picker: first enabled channel at or after ch, with a flag when none remain.
module sonar_rr_picker #(
   parameter int N_SONAR = 4
) (
   input  logic [3:0]         ch,
   input  logic [N_SONAR-1:0] en,
   output logic [3:0]         pick,
   output logic               none
);
   always_comb begin
      pick = 4'(N_SONAR);
      none = 1'b1;
      for (int i = N_SONAR - 1; i >= 0; i--)
         if (4'(i) >= ch && en[i]) begin
            pick = 4'(i);
            none = 1'b0;
         end
   end
endmodule

// File: rtl/sonar_ranging_sequencer.sv
// sonar_ranging_sequencer: round-robin SRF08 ranging over N_SONAR I2C sonars via a byte engine.
// Define SONAR_TIMEOUT_EN to abandon commands the byte engine never completes.
module sonar_ranging_sequencer
   import sonar_pkg::*;
#(
   parameter int N_SONAR        = 4,
   parameter int DIST_W         = 16,
   parameter int WAIT_CYCLES    = 3_250_000,
   parameter int TIMEOUT_CYCLES = 50_000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      launch,
   input  logic                      continuous,
   input  logic [N_SONAR-1:0]        ch_enable,
   input  logic [7*N_SONAR-1:0]      addr_tbl,
   output logic                      cmd_valid,
   output logic [1:0]                cmd_op,
   output logic                      cmd_start,
   output logic                      cmd_stop,
   output logic                      cmd_ack,
   output logic [7:0]                cmd_data,
   input  logic                      ready,
   input  logic [7:0]                data_out,
   input  logic                      nack,
   output logic [DIST_W*N_SONAR-1:0] distance,
   output logic [N_SONAR-1:0]        dist_valid,
   output logic [N_SONAR-1:0]        err,
   output logic                      result_valid,
   output logic [2:0]                result_ch,
   output logic                      busy,
   output logic                      sweep_done
);
   // One counter serves both the echo wait and the command timeout; they never overlap.
   localparam int CNT_W = $clog2((WAIT_CYCLES > TIMEOUT_CYCLES ? WAIT_CYCLES : TIMEOUT_CYCLES) + 1);
   state_t state, state_n;
   logic cv_n, good, bad, none, tmo, wr;
   logic [3:0] ch, ch_n, pick;
   logic [CNT_W-1:0] cnt;
   logic [7:0] hi;
   logic [6:0] addr;
   sonar_rr_picker #(.N_SONAR(N_SONAR)) u_pick (.ch(ch), .en(ch_enable), .pick(pick), .none(none));
   assign addr = 7'(addr_tbl >> (7 * ch));
   assign busy = state != IDLE;
   assign sweep_done = state == DONE;
   assign wr = state inside {W_ADDR, W_REG, W_CMD, R_ADDRW, R_REG, R_ADDRR};
`ifdef SONAR_TIMEOUT_EN
   assign tmo = cmd_valid && !ready && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_n = state;
      cv_n = cmd_valid;
      ch_n = ch;
      good = 1'b0;
      bad = 1'b0;
      case (state)
         IDLE: if (launch) begin
            state_n = SELECT;
            ch_n = '0;
         end
         SELECT: if (none) state_n = DONE;
         else if (pick == ch) begin
            state_n = W_ADDR;
            cv_n = 1'b1;
         end else ch_n = ch + 4'd1;
         WAIT: if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
            state_n = R_ADDRW;
            cv_n = 1'b1;
         end
         DONE: begin
            state_n = continuous ? SELECT : IDLE;
            ch_n = '0;
         end
         default: if (!cmd_valid) cv_n = 1'b1;
         else if (tmo) begin
            cv_n = 1'b0;
            bad = 1'b1;
         end else if (ready) begin
            cv_n = 1'b0;
            if (wr && nack) state_n = ABORT;
            else if (state == ABORT) bad = 1'b1;
            else if (state == R_LO) good = 1'b1;
            else state_n = next_step(state);
         end
      endcase
      if (good || bad) begin
         state_n = SELECT;
         ch_n = ch + 4'd1;
      end
   end
   always_comb begin
      cmd_op = OP_WRITE;
      cmd_start = 1'b0;
      cmd_stop = 1'b0;
      cmd_ack = 1'b0;
      cmd_data = '0;
      if (cmd_valid)
         case (state)
            W_ADDR, R_ADDRW: begin
               cmd_start = 1'b1;
               cmd_data = {addr, 1'b0};
            end
            W_REG: cmd_data = REG_CMD;
            W_CMD: begin
               cmd_data = CMD_RANGE_CM;
               cmd_stop = 1'b1;
            end
            R_REG: cmd_data = REG_RANGE_HI;
            R_ADDRR: begin
               cmd_start = 1'b1;
               cmd_data = {addr, 1'b1};
            end
            R_HI: begin
               cmd_op = OP_READ;
               cmd_ack = 1'b1;
            end
            R_LO: begin
               cmd_op = OP_READ;
               cmd_stop = 1'b1;
            end
            ABORT: begin
               cmd_op = OP_STOP;
               cmd_stop = 1'b1;
            end
            default: ;
         endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cmd_valid <= 1'b0;
         ch <= '0;
         cnt <= '0;
         hi <= '0;
         distance <= '0;
         dist_valid <= '0;
         err <= '0;
         result_valid <= 1'b0;
         result_ch <= '0;
      end else begin
         state <= state_n;
         cmd_valid <= cv_n;
         ch <= ch_n;
         cnt <= (state_n != state || cv_n != cmd_valid) ? '0 : cnt + 1'b1;
         result_valid <= good | bad;
         if (good | bad) result_ch <= ch[2:0];
         if (state == R_HI && cmd_valid && ready) hi <= data_out;
         for (int i = 0; i < N_SONAR; i++)
            if (ch == 4'(i)) begin
               if (good) begin
                  distance[i*DIST_W +: DIST_W] <= DIST_W'({hi, data_out});
                  dist_valid[i] <= 1'b1;
                  err[i] <= 1'b0;
               end
               if (bad) err[i] <= 1'b1;
            end
      end
   end
endmodule

// File: tb/tb_sonar_ranging_sequencer.sv
// tb_sonar_ranging_sequencer: randomized scoreboard bench with a byte-engine + SRF08 slave model.
module tb_sonar_ranging_sequencer;
   localparam int N = 2, DW = 16, WC = 10, TC = 20;
   logic clk = 1'b0, reset = 1'b1, launch = 1'b0, continuous = 1'b0;
   logic [N-1:0] ch_enable = '0;
   logic [7*N-1:0] addr_tbl = '0;
   logic cmd_valid, cmd_start, cmd_stop, cmd_ack;
   logic ready = 1'b0, nack = 1'b0;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data, data_out = '0;
   logic [DW*N-1:0] distance;
   logic [N-1:0] dist_valid, err;
   logic result_valid, busy, sweep_done;
   logic [2:0] result_ch;
   int checks = 0, passed = 0, t = 0, sd_cnt = 0, wait_t = 0;
   bit wait_armed = 0, prev_cv = 0, withhold = 0, cv_seen = 0;
   logic [12:0] cmd_q[$];
   logic [DW+3:0] res_q[$];
   logic [7:0] rng_hi[128], rng_lo[128];
   logic [6:0] nack_addr = 7'h7F, cur = '0;
   logic [DW-1:0] m_dist[N];
   logic [N-1:0] m_dv = '0, m_err = '0;

   sonar_ranging_sequencer #(.N_SONAR(N), .DIST_W(DW), .WAIT_CYCLES(WC), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .reset(reset), .launch(launch), .continuous(continuous), .ch_enable(ch_enable),
      .addr_tbl(addr_tbl), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_start(cmd_start),
      .cmd_stop(cmd_stop), .cmd_ack(cmd_ack), .cmd_data(cmd_data), .ready(ready),
      .data_out(data_out), .nack(nack), .distance(distance), .dist_valid(dist_valid), .err(err),
      .result_valid(result_valid), .result_ch(result_ch), .busy(busy), .sweep_done(sweep_done));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [12:0] c(input logic [1:0] op, input bit s, input bit p, input bit a,
                                     input logic [7:0] d);
      return {op, s, p, a, d};
   endfunction

   // Expected bus traffic and results of one sweep, from the SRF08 ranging recipe.
   task automatic model_sweep();
      logic [6:0] a;
      for (int i = 0; i < N; i++)
         if (ch_enable[i]) begin
            a = addr_tbl[7*i +: 7];
            cmd_q.push_back(c(2'b00, 1, 0, 0, {a, 1'b0}));
            if (a == nack_addr) begin
               cmd_q.push_back(c(2'b10, 0, 1, 0, 8'h00));
               m_err[i] = 1'b1;
            end else begin
               cmd_q.push_back(c(2'b00, 0, 0, 0, 8'h00));
               cmd_q.push_back(c(2'b00, 0, 1, 0, 8'h51));
               cmd_q.push_back(c(2'b00, 1, 0, 0, {a, 1'b0}));
               cmd_q.push_back(c(2'b00, 0, 0, 0, 8'h02));
               cmd_q.push_back(c(2'b00, 1, 0, 0, {a, 1'b1}));
               cmd_q.push_back(c(2'b01, 0, 0, 1, 8'h00));
               cmd_q.push_back(c(2'b01, 0, 1, 0, 8'h00));
               m_dist[i] = {rng_hi[a], rng_lo[a]};
               m_dv[i] = 1'b1;
               m_err[i] = 1'b0;
            end
            res_q.push_back({3'(i), m_err[i], m_dist[i]});
         end
   endtask

   task automatic do_launch();
      launch = 1'b1;
      @(negedge clk);
      launch = 1'b0;
   endtask

   task automatic finish_sweep(input string name);
      int n = 0;
      logic [DW*N-1:0] ed;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_bounded"}, 32'(n < 3000), 1);
      @(negedge clk);
      for (int i = 0; i < N; i++) ed[DW*i +: DW] = m_dist[i];
      chk({name, "_cmdq_left"}, cmd_q.size(), 0);
      chk({name, "_resq_left"}, res_q.size(), 0);
      chk({name, "_distance"}, distance, ed);
      chk({name, "_dist_valid"}, dist_valid, m_dv);
      chk({name, "_err"}, err, m_err);
   endtask

   // Byte engine: completes each command after a random 0..3 cycle delay.
   initial forever begin
      @(posedge clk);
      #1;
      ready = 1'b0;
      nack = 1'b0;
      if (cmd_valid && !reset && !withhold) begin
         for (int d = $urandom_range(0, 3); d > 0; d--) begin
            @(posedge clk);
            #1;
         end
         if (cmd_valid && !reset) begin
            ready = 1'b1;
            nack = cmd_op == 2'b00 && cmd_start && cmd_data[7:1] == nack_addr;
            if (cmd_op == 2'b00 && cmd_start && cmd_data[0]) cur = cmd_data[7:1];
            data_out = cmd_op == 2'b01 ? (cmd_ack ? rng_hi[cur] : rng_lo[cur]) : 8'($urandom);
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT completes a command or reports a result.
   initial forever begin
      logic [12:0] act;
      @(negedge clk);
      t++;
      if (reset) begin
         prev_cv = 0;
         wait_armed = 0;
      end else begin
         if (cmd_valid) cv_seen = 1;
         if (cmd_valid && !prev_cv && wait_armed) begin
            chk("echo_wait", t - wait_t, WC + 1);
            wait_armed = 0;
         end
         prev_cv = cmd_valid;
         if (cmd_valid && ready) begin
            act = {cmd_op, cmd_start, cmd_stop, cmd_ack, cmd_data};
            chk("cmd", 32'(act), cmd_q.size() > 0 ? 32'(cmd_q.pop_front()) : 32'h1FFF);
            if (act == c(2'b00, 0, 1, 0, 8'h51)) begin
               wait_armed = 1;
               wait_t = t;
            end
         end
         if (result_valid)
            chk("result", {result_ch, 1'(err >> result_ch), DW'(distance >> (DW * result_ch))},
                res_q.size() > 0 ? 32'(res_q.pop_front()) : 32'hFFFFF);
         if (sweep_done) sd_cnt++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, sd0;
      logic [6:0] a0, a1;
      for (int i = 0; i < 128; i++) begin
         rng_hi[i] = 8'($urandom);
         rng_lo[i] = 8'($urandom);
      end
      for (int i = 0; i < N; i++) m_dist[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd", {cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_ack, cmd_data}, 0);
      chk("rst_status", {busy, sweep_done, result_valid, result_ch}, 0);
      chk("rst_distance", distance, 0);
      chk("rst_flags", {dist_valid, err}, 0);
      reset = 1'b0;
      @(negedge clk);
      addr_tbl = {7'h70, 7'h5E};
      rng_hi[7'h5E] = 8'h01;
      rng_lo[7'h5E] = 8'h03;
      rng_hi[7'h70] = 8'h00;
      rng_lo[7'h70] = 8'h2A;
      ch_enable = 2'b11;
      nack_addr = 7'h70;
      model_sweep();
      do_launch();
      finish_sweep("nack");
      chk("nack_dist1_zero", distance[2*DW-1:DW], 0);
      nack_addr = 7'h7F;
      sd0 = sd_cnt;
      model_sweep();
      launch = 1'b1;
      @(negedge clk);
      launch = 1'b0;
      chk("launch_busy", busy, 1);
      chk("launch_cv_early", cmd_valid, 0);
      @(negedge clk);
      chk("launch_cv", cmd_valid, 1);
      finish_sweep("basic");
      chk("basic_distance", distance, 32'h002A_0103);
      chk("basic_sweeps", sd_cnt - sd0, 1);
      ch_enable = '0;
      cv_seen = 0;
      launch = 1'b1;
      @(negedge clk);
      launch = 1'b0;
      n = 1;
      while (!sweep_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("empty_latency", 32'(n <= N + 2), 1);
      finish_sweep("empty");
      chk("empty_no_cmd", cv_seen, 0);
      ch_enable = 2'b11;
      continuous = 1'b1;
      sd0 = sd_cnt;
      model_sweep();
      model_sweep();
      do_launch();
      n = 0;
      while (!sweep_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("cont_first_done", 32'(n < 3000), 1);
      @(negedge clk);
      continuous = 1'b0;
      do_launch();
      chk("cont_restarted", busy, 1);
      finish_sweep("cont");
      chk("cont_sweeps", sd_cnt - sd0, 2);
      repeat (6) begin
         a0 = 7'($urandom_range(0, 126));
         do a1 = 7'($urandom_range(0, 126)); while (a1 == a0);
         addr_tbl = {a1, a0};
         rng_hi[a0] = 8'($urandom);
         rng_lo[a0] = 8'($urandom);
         rng_hi[a1] = 8'($urandom);
         rng_lo[a1] = 8'($urandom);
         ch_enable = 2'($urandom_range(1, 3));
         n = $urandom_range(0, 2);
         nack_addr = n == 0 ? a0 : n == 1 ? a1 : 7'h7F;
         model_sweep();
         do_launch();
         finish_sweep("rand");
      end
      nack_addr = 7'h7F;
`ifdef SONAR_TIMEOUT_EN
      ch_enable = 2'b01;
      withhold = 1;
      do_launch();
      n = 0;
      while (!cmd_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (cmd_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_len", n, TC);
      withhold = 0;
      m_err[0] = 1'b1;
      res_q.push_back({3'd0, 1'b1, m_dist[0]});
      finish_sweep("timeout");
`endif
      ch_enable = 2'b01;
      model_sweep();
      do_launch();
      n = 0;
      while (!wait_armed && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("wait_state_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst2_cmd", {cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_ack, cmd_data}, 0);
      chk("rst2_status", {busy, sweep_done, result_valid, result_ch}, 0);
      chk("rst2_distance", distance, 0);
      chk("rst2_flags", {dist_valid, err}, 0);
      reset = 1'b0;
      cmd_q.delete();
      res_q.delete();
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
